// File: rtl/ram_arb_pkg.sv
// Shared types for the solver RAM arbiter: ownership states and requester indices.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam bit REQ_SOLVER = 1'b0;
  localparam bit REQ_INTERP = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side bundle of the arbiter. Index 0 is the solver, index 1 the interpolator.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 13
);
  logic [1:0]                    req_i;
  logic [1:0]                    gnt_o;
  logic [1:0][ADDRESS_WIDTH-1:0] rd1_add_i;
  logic [1:0][ADDRESS_WIDTH-1:0] rd2_add_i;
  logic [1:0][ADDRESS_WIDTH-1:0] wr_add_i;
  logic [1:0][DATA_WIDTH-1:0]    wr_data_i;
  logic [1:0]                    wr_en_i;
  logic [1:0]                    rd_valid_o;
  logic [ADDRESS_WIDTH-1:0]      ram_add_rd1_o;
  logic [ADDRESS_WIDTH-1:0]      ram_add_rd2_o;
  logic [ADDRESS_WIDTH-1:0]      ram_add_wr_o;
  logic [DATA_WIDTH-1:0]         ram_data_wr_o;
  logic                          ram_enable_wr_o;
  logic                          error_o;

  modport slave (
    input  req_i, rd1_add_i, rd2_add_i, wr_add_i, wr_data_i, wr_en_i,
    output gnt_o, rd_valid_o, ram_add_rd1_o, ram_add_rd2_o, ram_add_wr_o,
           ram_data_wr_o, ram_enable_wr_o, error_o
  );

  modport master (
    output req_i, rd1_add_i, rd2_add_i, wr_add_i, wr_data_i, wr_en_i,
    input  gnt_o, rd_valid_o, ram_add_rd1_o, ram_add_rd2_o, ram_add_wr_o,
           ram_data_wr_o, ram_enable_wr_o, error_o
  );
endinterface

// File: rtl/ram_arb_port_mux.sv
// Steers the owning requester's addresses, write data and write enable onto the RAM; all zero when idle.
module ram_arb_port_mux
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 13
) (
  input  arb_state_e                    state_i,
  input  logic [1:0][ADDRESS_WIDTH-1:0] rd1_add_i,
  input  logic [1:0][ADDRESS_WIDTH-1:0] rd2_add_i,
  input  logic [1:0][ADDRESS_WIDTH-1:0] wr_add_i,
  input  logic [1:0][DATA_WIDTH-1:0]    wr_data_i,
  input  logic [1:0]                    wr_en_i,
  output logic [ADDRESS_WIDTH-1:0]      ram_add_rd1_o,
  output logic [ADDRESS_WIDTH-1:0]      ram_add_rd2_o,
  output logic [ADDRESS_WIDTH-1:0]      ram_add_wr_o,
  output logic [DATA_WIDTH-1:0]         ram_data_wr_o,
  output logic                          ram_enable_wr_o
);

  always_comb begin
    ram_add_rd1_o   = '0;
    ram_add_rd2_o   = '0;
    ram_add_wr_o    = '0;
    ram_data_wr_o   = '0;
    ram_enable_wr_o = 1'b0;
    case (state_i)
      OWN0: begin
        ram_add_rd1_o   = rd1_add_i[REQ_SOLVER];
        ram_add_rd2_o   = rd2_add_i[REQ_SOLVER];
        ram_add_wr_o    = wr_add_i[REQ_SOLVER];
        ram_data_wr_o   = wr_data_i[REQ_SOLVER];
        ram_enable_wr_o = wr_en_i[REQ_SOLVER];
      end
      OWN1: begin
        ram_add_rd1_o   = rd1_add_i[REQ_INTERP];
        ram_add_rd2_o   = rd2_add_i[REQ_INTERP];
        ram_add_wr_o    = wr_add_i[REQ_INTERP];
        ram_data_wr_o   = wr_data_i[REQ_INTERP];
        ram_enable_wr_o = wr_en_i[REQ_INTERP];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin, hold-bounded ownership arbiter for the solver RAM.
// Optional sticky write-protocol checker enabled by RAM_ARB_ERROR_EN.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 13,
  parameter int MAX_HOLD      = 16
) (
  input logic              clk,
  input logic              rst,
  ram_port_arbiter_if.slave bus
);

  localparam int              HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              last_q, last_d;
  logic [1:0]        rd_valid_q, rd_valid_d;
  logic [1:0]        gnt;
  logic              other_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      last_q     <= REQ_INTERP;
      rd_valid_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      last_q     <= last_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    last_d    = last_q;
    other_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_i[0] && bus.req_i[1]) state_d = (last_q == REQ_SOLVER) ? OWN1 : OWN0;
        else if (bus.req_i[0])            state_d = OWN0;
        else if (bus.req_i[1])            state_d = OWN1;
      end
      OWN0: begin
        other_req = bus.req_i[1];
        if (!bus.req_i[0])                         state_d = bus.req_i[1] ? OWN1 : IDLE;
        else if (bus.req_i[1] && hold_q == HOLD_LAST) state_d = OWN1;
      end
      OWN1: begin
        other_req = bus.req_i[0];
        if (!bus.req_i[1])                         state_d = bus.req_i[0] ? OWN0 : IDLE;
        else if (bus.req_i[0] && hold_q == HOLD_LAST) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase

    // Any entry into an OWN state restarts the hold window and records the new owner.
    if (state_d != state_q && state_d != IDLE) begin
      hold_d = '0;
      last_d = (state_d == OWN1);
    end else if (other_req && hold_q != HOLD_LAST) begin
      hold_d = hold_q + 1'b1;
    end

    rd_valid_d = gnt;
  end

  assign gnt            = {state_q == OWN1, state_q == OWN0};
  assign bus.gnt_o      = gnt;
  assign bus.rd_valid_o = rd_valid_q;

  ram_arb_port_mux #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_port_mux (
    .state_i         (state_q),
    .rd1_add_i       (bus.rd1_add_i),
    .rd2_add_i       (bus.rd2_add_i),
    .wr_add_i        (bus.wr_add_i),
    .wr_data_i       (bus.wr_data_i),
    .wr_en_i         (bus.wr_en_i),
    .ram_add_rd1_o   (bus.ram_add_rd1_o),
    .ram_add_rd2_o   (bus.ram_add_rd2_o),
    .ram_add_wr_o    (bus.ram_add_wr_o),
    .ram_data_wr_o   (bus.ram_data_wr_o),
    .ram_enable_wr_o (bus.ram_enable_wr_o)
  );

`ifdef RAM_ARB_ERROR_EN
  logic error_q, error_d;

  assign error_d = error_q | (|(bus.wr_en_i & ~gnt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) error_q <= 1'b0;
    else     error_q <= error_d;
  end

  assign bus.error_o = error_q;
`else
  assign bus.error_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with MAX_HOLD=4; error expectations follow RAM_ARB_ERROR_EN.
module tb_ram_port_arbiter;
  localparam int DW = 64;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic exp_err;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req_i     = '0;
    bus.rd1_add_i = '0;
    bus.rd2_add_i = '0;
    bus.wr_add_i  = '0;
    bus.wr_data_i = '0;
    bus.wr_en_i   = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_gnt", 64'(bus.gnt_o), 64'h0);
    chk("reset_rd_valid", 64'(bus.rd_valid_o), 64'h0);
    chk("reset_wr_en", 64'(bus.ram_enable_wr_o), 64'h0);
    chk("reset_error", 64'(bus.error_o), 64'h0);

    // Solver alone writes 0xAA to address 5
    bus.req_i[0]     = 1'b1;
    bus.wr_en_i[0]   = 1'b1;
    bus.wr_add_i[0]  = 13'd5;
    bus.wr_data_i[0] = 64'hAA;
    #1;
    chk("idle_wr_discard", 64'(bus.ram_enable_wr_o), 64'h0);
    tick();
    chk("solo_gnt", 64'(bus.gnt_o), 64'h1);
    chk("solo_wr_en", 64'(bus.ram_enable_wr_o), 64'h1);
    chk("solo_wr_add", 64'(bus.ram_add_wr_o), 64'h5);
    chk("solo_wr_data", bus.ram_data_wr_o, 64'hAA);
    bus.req_i[0]   = 1'b0;
    bus.wr_en_i[0] = 1'b0;
    tick();
    chk("solo_release_gnt", 64'(bus.gnt_o), 64'h0);
    chk("solo_rd_valid", 64'(bus.rd_valid_o), 64'h1);
    tick();
    chk("solo_rd_valid_end", 64'(bus.rd_valid_o), 64'h0);

    // Both request out of reset: solver wins, handover without a bubble
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.req_i = 2'b11;
    tick();
    chk("tie_first_gnt", 64'(bus.gnt_o), 64'h1);
    tick();
    chk("tie_hold_gnt2", 64'(bus.gnt_o), 64'h1);
    tick();
    chk("tie_hold_gnt3", 64'(bus.gnt_o), 64'h1);
    bus.req_i[0] = 1'b0;
    tick();
    chk("handover_gnt", 64'(bus.gnt_o), 64'h2);
    bus.req_i[1] = 1'b0;
    tick();
    chk("handover_release", 64'(bus.gnt_o), 64'h0);

    // Preemption after four cycles of the interpolator waiting
    bus.req_i[0] = 1'b1;
    tick();
    chk("pre_own0", 64'(bus.gnt_o), 64'h1);
    bus.req_i[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("pre_wait%0d", i), 64'(bus.gnt_o), 64'h1);
    end
    tick();
    chk("preempt_gnt", 64'(bus.gnt_o), 64'h2);
    bus.req_i[1] = 1'b0;
    tick();
    chk("resume_gnt", 64'(bus.gnt_o), 64'h1);
    bus.req_i[0] = 1'b0;
    tick();
    chk("resume_release", 64'(bus.gnt_o), 64'h0);

    // Read routing and one-cycle valid that follows the previous owner
    bus.rd1_add_i[0] = 13'd3;
    bus.rd1_add_i[1] = 13'd7;
    bus.rd2_add_i[1] = 13'd9;
    bus.req_i[1]     = 1'b1;
    #1;
    chk("idle_rd1_zero", 64'(bus.ram_add_rd1_o), 64'h0);
    tick();
    chk("rd_gnt1", 64'(bus.gnt_o), 64'h2);
    chk("rd_add_rd1", 64'(bus.ram_add_rd1_o), 64'h7);
    chk("rd_add_rd2", 64'(bus.ram_add_rd2_o), 64'h9);
    bus.req_i[0] = 1'b1;
    bus.req_i[1] = 1'b0;
    tick();
    chk("rd_valid_after_move", 64'(bus.rd_valid_o), 64'h2);
    chk("rd_new_owner", 64'(bus.gnt_o), 64'h1);
    chk("rd_add_rd1_own0", 64'(bus.ram_add_rd1_o), 64'h3);
    tick();
    chk("rd_valid_own0", 64'(bus.rd_valid_o), 64'h1);
    bus.req_i[0] = 1'b0;
    tick();
    chk("rd_release", 64'(bus.gnt_o), 64'h0);

    // Asynchronous reset while the interpolator is writing
    clear_inputs();
    bus.req_i[1] = 1'b1;
    tick();
    bus.wr_en_i[1] = 1'b1;
    #1;
    chk("rst_pre_wr_en", 64'(bus.ram_enable_wr_o), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_gnt", 64'(bus.gnt_o), 64'h0);
    chk("rst_async_wr_en", 64'(bus.ram_enable_wr_o), 64'h0);
    chk("rst_async_rd_valid", 64'(bus.rd_valid_o), 64'h0);
    tick();
    chk("rst_dropped_read", 64'(bus.rd_valid_o), 64'h0);
    bus.wr_en_i[1] = 1'b0;
    bus.req_i      = 2'b11;
    rst = 1'b0;
    tick();
    chk("post_rst_tie", 64'(bus.gnt_o), 64'h1);
    clear_inputs();
    tick();

    // Ungranted write: never reaches the RAM, flags the checker when built in
`ifdef RAM_ARB_ERROR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.wr_en_i[1] = 1'b1;
    #1;
    chk("ungranted_wr_en", 64'(bus.ram_enable_wr_o), 64'h0);
    chk("err_before", 64'(bus.error_o), 64'h0);
    tick();
    chk("err_set", 64'(bus.error_o), 64'(exp_err));
    bus.wr_en_i[1] = 1'b0;
    tick();
    tick();
    chk("err_sticky", 64'(bus.error_o), 64'(exp_err));
    rst = 1'b1;
    #1;
    chk("err_cleared", 64'(bus.error_o), 64'h0);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
